// File: rtl/riscv_pkg.sv
// ============================================================================
// riscv_pkg : RV32I encodings, one-hot op bit positions and immediate helper
// Rev 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB   = 3'b000;
  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;

  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_SH   = 3'b001;
  localparam logic [2:0] F3_SW   = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

  localparam int OP_BEQ   = 0;
  localparam int OP_BNE   = 1;
  localparam int OP_BLT   = 2;
  localparam int OP_BGE   = 3;
  localparam int OP_BLTU  = 4;
  localparam int OP_BGEU  = 5;
  localparam int OP_ADD   = 6;
  localparam int OP_SUB   = 7;
  localparam int OP_SLL   = 8;
  localparam int OP_SLT   = 9;
  localparam int OP_SLTU  = 10;
  localparam int OP_XOR   = 11;
  localparam int OP_SRL   = 12;
  localparam int OP_SRA   = 13;
  localparam int OP_OR    = 14;
  localparam int OP_AND   = 15;
  localparam int OP_ADDI  = 16;
  localparam int OP_SLTI  = 17;
  localparam int OP_SLTIU = 18;
  localparam int OP_XORI  = 19;
  localparam int OP_ORI   = 20;
  localparam int OP_ANDI  = 21;
  localparam int OP_SLLI  = 22;
  localparam int OP_SRLI  = 23;
  localparam int OP_SRAI  = 24;
  localparam int OP_LUI   = 25;
  localparam int OP_AUIPC = 26;
  localparam int OP_JAL   = 27;
  localparam int OP_JALR  = 28;
  localparam int OP_JUMP  = 29;
  localparam int OP_LB    = 30;
  localparam int OP_LH    = 31;
  localparam int OP_LW    = 32;
  localparam int OP_LBU   = 33;
  localparam int OP_LHU   = 34;
  localparam int OP_SB    = 35;
  localparam int OP_SH    = 36;
  localparam int OP_SW    = 37;
  localparam int OP_ECALL = 38;
  // Bit 39 is reserved and always driven 0.
  localparam int NUM_OPS  = 40;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_SH   = 3'd6
  } imm_fmt_e;

  typedef enum logic [1:0] {
    A_RS1  = 2'd0,
    A_PC   = 2'd1,
    A_ZERO = 2'd2
  } a_sel_e;

  function automatic logic [31:0] gen_imm(input imm_fmt_e fmt, input logic [31:7] ins);
    logic [31:0] imm;
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm = {ins[31:12], 12'b0};
      IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      IMM_SH:  imm = {27'b0, ins[24:20]};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_regfile.sv
// ============================================================================
// riscv_regfile : 32 x XLEN integer register file, 2R/1W, write-through bypass
// Rev 1.0
// ============================================================================
`default_nettype none

module riscv_regfile #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      raddr_a_i,
  input  logic [4:0]      raddr_b_i,
  output logic [XLEN-1:0] rdata_a_o,
  output logic [XLEN-1:0] rdata_b_o
);

  logic [XLEN-1:0] mem_q [32];
  logic            wr_en;

  assign wr_en = we_i && (waddr_i != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Same-cycle write is forwarded so the reader never sees the stale value.
  always_comb begin
    rdata_a_o = mem_q[raddr_a_i];
    rdata_b_o = mem_q[raddr_b_i];
    if (wr_en && (waddr_i == raddr_a_i)) rdata_a_o = wdata_i;
    if (wr_en && (waddr_i == raddr_b_i)) rdata_b_o = wdata_i;
    if (raddr_a_i == 5'd0) rdata_a_o = '0;
    if (raddr_b_i == 5'd0) rdata_b_o = '0;
  end

endmodule

`default_nettype wire

// File: rtl/riscv_decode_stage.sv
// ============================================================================
// riscv_decode_stage : RV32I decode/issue with RAW scoreboard and output register
// Rev 1.0
// ============================================================================
`default_nettype none

module riscv_decode_stage #(
  parameter int XLEN    = 32,
  parameter int NUM_OPS = riscv_pkg::NUM_OPS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid_i,
  output logic               if_ready_o,
  input  logic [31:0]        if_instr_i,
  input  logic [XLEN-1:0]    if_pc_i,
  input  logic               wb_en_i,
  input  logic [4:0]         wb_rd_i,
  input  logic [XLEN-1:0]    wb_data_i,
  input  logic               flush_i,
  output logic               id_valid_o,
  input  logic               id_ready_i,
  output logic [NUM_OPS-1:0] id_op_o,
  output logic [XLEN-1:0]    id_alu_a_o,
  output logic [XLEN-1:0]    id_alu_b_o,
  output logic [XLEN-1:0]    id_rs2_o,
  output logic [XLEN-1:0]    id_imm_o,
  output logic [4:0]         id_rd_o,
  output logic [XLEN-1:0]    id_pc_o,
  output logic               id_illegal_o
);

  import riscv_pkg::*;

  logic [6:0]         opcode, funct7;
  logic [2:0]         funct3;
  logic [4:0]         rs1_idx, rs2_idx, rd_idx, dec_rd;
  logic [NUM_OPS-1:0] dec_op;
  imm_fmt_e           imm_fmt;
  a_sel_e             a_sel;
  logic               b_is_rs2, use_rs1, use_rs2, writes_rd, illegal;
  logic [XLEN-1:0]    rs1_val, rs2_val, imm_val, alu_a, alu_b;
  logic               hazard, issue;

  logic               id_valid_q, id_valid_d;
  logic [NUM_OPS-1:0] id_op_q;
  logic [XLEN-1:0]    id_alu_a_q, id_alu_b_q, id_rs2_q, id_imm_q, id_pc_q;
  logic [4:0]         id_rd_q;
  logic               id_illegal_q;
  logic [31:0]        busy_q, busy_d;

  assign opcode  = if_instr_i[6:0];
  assign rd_idx  = if_instr_i[11:7];
  assign funct3  = if_instr_i[14:12];
  assign rs1_idx = if_instr_i[19:15];
  assign rs2_idx = if_instr_i[24:20];
  assign funct7  = if_instr_i[31:25];

  always_comb begin
    dec_op    = '0;
    imm_fmt   = IMM_NONE;
    a_sel     = A_RS1;
    b_is_rs2  = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    writes_rd = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec_op[OP_LUI] = 1'b1; imm_fmt = IMM_U; a_sel = A_ZERO; writes_rd = 1'b1;
      end
      OPC_AUIPC: begin
        dec_op[OP_AUIPC] = 1'b1; imm_fmt = IMM_U; a_sel = A_PC; writes_rd = 1'b1;
      end
      OPC_JAL: begin
        dec_op[OP_JAL] = 1'b1; dec_op[OP_JUMP] = 1'b1;
        imm_fmt = IMM_J; a_sel = A_PC; writes_rd = 1'b1;
      end
      OPC_JALR: begin
        dec_op[OP_JALR] = 1'b1; dec_op[OP_JUMP] = 1'b1;
        imm_fmt = IMM_I; use_rs1 = 1'b1; writes_rd = 1'b1;
        illegal = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        imm_fmt = IMM_B; use_rs1 = 1'b1; use_rs2 = 1'b1; b_is_rs2 = 1'b1;
        case (funct3)
          F3_BEQ:  dec_op[OP_BEQ]  = 1'b1;
          F3_BNE:  dec_op[OP_BNE]  = 1'b1;
          F3_BLT:  dec_op[OP_BLT]  = 1'b1;
          F3_BGE:  dec_op[OP_BGE]  = 1'b1;
          F3_BLTU: dec_op[OP_BLTU] = 1'b1;
          F3_BGEU: dec_op[OP_BGEU] = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        imm_fmt = IMM_I; use_rs1 = 1'b1; writes_rd = 1'b1;
        case (funct3)
          F3_LB:   dec_op[OP_LB]  = 1'b1;
          F3_LH:   dec_op[OP_LH]  = 1'b1;
          F3_LW:   dec_op[OP_LW]  = 1'b1;
          F3_LBU:  dec_op[OP_LBU] = 1'b1;
          F3_LHU:  dec_op[OP_LHU] = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        imm_fmt = IMM_S; use_rs1 = 1'b1; use_rs2 = 1'b1;
        case (funct3)
          F3_SB:   dec_op[OP_SB] = 1'b1;
          F3_SH:   dec_op[OP_SH] = 1'b1;
          F3_SW:   dec_op[OP_SW] = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        imm_fmt = IMM_I; use_rs1 = 1'b1; writes_rd = 1'b1;
        case (funct3)
          F3_ADD:  dec_op[OP_ADDI]  = 1'b1;
          F3_SLT:  dec_op[OP_SLTI]  = 1'b1;
          F3_SLTU: dec_op[OP_SLTIU] = 1'b1;
          F3_XOR:  dec_op[OP_XORI]  = 1'b1;
          F3_OR:   dec_op[OP_ORI]   = 1'b1;
          F3_AND:  dec_op[OP_ANDI]  = 1'b1;
          F3_SLL: begin
            imm_fmt = IMM_SH;
            if (funct7 == F7_BASE) dec_op[OP_SLLI] = 1'b1;
            else                   illegal = 1'b1;
          end
          default: begin
            imm_fmt = IMM_SH;
            if (funct7 == F7_BASE)     dec_op[OP_SRLI] = 1'b1;
            else if (funct7 == F7_ALT) dec_op[OP_SRAI] = 1'b1;
            else                       illegal = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; b_is_rs2 = 1'b1; writes_rd = 1'b1;
        if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD:  dec_op[OP_ADD]  = 1'b1;
            F3_SLL:  dec_op[OP_SLL]  = 1'b1;
            F3_SLT:  dec_op[OP_SLT]  = 1'b1;
            F3_SLTU: dec_op[OP_SLTU] = 1'b1;
            F3_XOR:  dec_op[OP_XOR]  = 1'b1;
            F3_SRL:  dec_op[OP_SRL]  = 1'b1;
            F3_OR:   dec_op[OP_OR]   = 1'b1;
            default: dec_op[OP_AND]  = 1'b1;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          dec_op[OP_SUB] = 1'b1;
        end else if (funct7 == F7_ALT && funct3 == F3_SRL) begin
          dec_op[OP_SRA] = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_SYSTEM: begin
        if (if_instr_i == ECALL_WORD) dec_op[OP_ECALL] = 1'b1;
        else                          illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    // An illegal word issues as a no-op bundle that neither reads nor writes registers.
    if (illegal) begin
      dec_op    = '0;
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
      writes_rd = 1'b0;
    end
  end

  riscv_regfile #(.XLEN(XLEN)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we_i      (wb_en_i),
    .waddr_i   (wb_rd_i),
    .wdata_i   (wb_data_i),
    .raddr_a_i (rs1_idx),
    .raddr_b_i (rs2_idx),
    .rdata_a_o (rs1_val),
    .rdata_b_o (rs2_val)
  );

  assign imm_val = gen_imm(imm_fmt, if_instr_i[31:7]);
  assign dec_rd  = writes_rd ? rd_idx : 5'd0;

  always_comb begin
    case (a_sel)
      A_PC:    alu_a = if_pc_i;
      A_ZERO:  alu_a = '0;
      default: alu_a = rs1_val;
    endcase
    alu_b = b_is_rs2 ? rs2_val : imm_val;
  end

  // A busy source is harmless when its write-back lands this cycle (bypass serves it).
  assign hazard = (use_rs1 && busy_q[rs1_idx] && !(wb_en_i && wb_rd_i == rs1_idx)) ||
                  (use_rs2 && busy_q[rs2_idx] && !(wb_en_i && wb_rd_i == rs2_idx));

  assign if_ready_o = !flush_i && !hazard && (!id_valid_q || id_ready_i);
  assign issue      = if_valid_i && if_ready_o;
  assign id_valid_d = issue || (id_valid_q && !id_ready_i && !flush_i);

  always_comb begin
    busy_d = busy_q;
    if (wb_en_i) busy_d[wb_rd_i] = 1'b0;
    if (flush_i && id_valid_q && !id_ready_i) busy_d[id_rd_q] = 1'b0;
    if (issue) busy_d[dec_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid_q   <= 1'b0;
      busy_q       <= '0;
      id_op_q      <= '0;
      id_alu_a_q   <= '0;
      id_alu_b_q   <= '0;
      id_rs2_q     <= '0;
      id_imm_q     <= '0;
      id_rd_q      <= '0;
      id_pc_q      <= '0;
      id_illegal_q <= 1'b0;
    end else begin
      id_valid_q <= id_valid_d;
      busy_q     <= busy_d;
      if (issue) begin
        id_op_q      <= dec_op;
        id_alu_a_q   <= alu_a;
        id_alu_b_q   <= alu_b;
        id_rs2_q     <= rs2_val;
        id_imm_q     <= imm_val;
        id_rd_q      <= dec_rd;
        id_pc_q      <= if_pc_i;
        id_illegal_q <= illegal;
      end
    end
  end

  assign id_valid_o   = id_valid_q;
  assign id_op_o      = id_op_q;
  assign id_alu_a_o   = id_alu_a_q;
  assign id_alu_b_o   = id_alu_b_q;
  assign id_rs2_o     = id_rs2_q;
  assign id_imm_o     = id_imm_q;
  assign id_rd_o      = id_rd_q;
  assign id_pc_o      = id_pc_q;
  assign id_illegal_o = id_illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_riscv_decode_stage.sv
// ============================================================================
// tb_riscv_decode_stage : directed self-checking bench for riscv_decode_stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_riscv_decode_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid_i, if_ready_o;
  logic [31:0] if_instr_i, if_pc_i;
  logic        wb_en_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        flush_i;
  logic        id_valid_o, id_ready_i;
  logic [NUM_OPS-1:0] id_op_o;
  logic [31:0] id_alu_a_o, id_alu_b_o, id_rs2_o, id_imm_o, id_pc_o;
  logic [4:0]  id_rd_o;
  logic        id_illegal_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_decode_stage dut (
    .clk          (clk),
    .rst          (rst),
    .if_valid_i   (if_valid_i),
    .if_ready_o   (if_ready_o),
    .if_instr_i   (if_instr_i),
    .if_pc_i      (if_pc_i),
    .wb_en_i      (wb_en_i),
    .wb_rd_i      (wb_rd_i),
    .wb_data_i    (wb_data_i),
    .flush_i      (flush_i),
    .id_valid_o   (id_valid_o),
    .id_ready_i   (id_ready_i),
    .id_op_o      (id_op_o),
    .id_alu_a_o   (id_alu_a_o),
    .id_alu_b_o   (id_alu_b_o),
    .id_rs2_o     (id_rs2_o),
    .id_imm_o     (id_imm_o),
    .id_rd_o      (id_rd_o),
    .id_pc_o      (id_pc_o),
    .id_illegal_o (id_illegal_o)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] opbit(input int idx);
    return 64'd1 << idx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    if_valid_i = 1'b1;
    if_instr_i = instr;
    if_pc_i    = pc;
  endtask

  task automatic bundle(input string tag, input logic [63:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    chk({tag, " valid"}, 64'(id_valid_o), 64'd1);
    chk({tag, " op"},    64'(id_op_o),    op);
    chk({tag, " alu_a"}, 64'(id_alu_a_o), 64'(a));
    chk({tag, " alu_b"}, 64'(id_alu_b_o), 64'(b));
    chk({tag, " rd"},    64'(id_rd_o),    64'(rd));
  endtask

  initial begin
    rst = 1'b1; if_valid_i = 1'b0; if_instr_i = '0; if_pc_i = '0;
    wb_en_i = 1'b0; wb_rd_i = '0; wb_data_i = '0; flush_i = 1'b0; id_ready_i = 1'b1;
    repeat (2) tick();
    chk("rst valid",   64'(id_valid_o),   64'd0);
    chk("rst op",      64'(id_op_o),      64'd0);
    chk("rst alu_a",   64'(id_alu_a_o),   64'd0);
    chk("rst imm",     64'(id_imm_o),     64'd0);
    chk("rst illegal", 64'(id_illegal_o), 64'd0);
    rst = 1'b0;
    #1 chk("post-rst ready", 64'(if_ready_o), 64'd1);

    // x1=10, x2=15, then add x3,x1,x2
    wb_en_i = 1'b1; wb_rd_i = 5'd1; wb_data_i = 32'd10; tick();
    wb_rd_i = 5'd2; wb_data_i = 32'd15; tick();
    wb_en_i = 1'b0;
    present(32'h002081B3, 32'h40);
    #1 chk("add ready", 64'(if_ready_o), 64'd1);
    chk("add pre valid", 64'(id_valid_o), 64'd0);
    tick();
    if_valid_i = 1'b0;
    bundle("add", opbit(OP_ADD), 32'd10, 32'd15, 5'd3);
    chk("add pc", 64'(id_pc_o), 64'h40);

    // addi x5,x0,-1 then and x6,x5,x5 stalls until write-back of x5
    present(32'hFFF00293, 32'h44);
    tick();
    bundle("addi", opbit(OP_ADDI), 32'd0, 32'hFFFF_FFFF, 5'd5);
    chk("addi imm", 64'(id_imm_o), 64'hFFFF_FFFF);
    present(32'h0052F333, 32'h48);
    #1 chk("and stall0", 64'(if_ready_o), 64'd0);
    tick();
    chk("and stall1", 64'(if_ready_o), 64'd0);
    chk("and stall valid", 64'(id_valid_o), 64'd0);
    wb_en_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'hFFFF_FFFF;
    #1 chk("and bypass ready", 64'(if_ready_o), 64'd1);
    tick();
    wb_en_i = 1'b0; if_valid_i = 1'b0;
    bundle("and", opbit(OP_AND), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);

    // auipc x7,0x1 @0x100 ; jal x1,8 @0x104
    present(32'h00001397, 32'h100);
    tick();
    bundle("auipc", opbit(OP_AUIPC), 32'h100, 32'h1000, 5'd7);
    present(32'h008000EF, 32'h104);
    tick();
    if_valid_i = 1'b0;
    bundle("jal", opbit(OP_JAL) | opbit(OP_JUMP), 32'h104, 32'd8, 5'd1);
    chk("jal imm", 64'(id_imm_o), 64'd8);
    wb_en_i = 1'b1; wb_rd_i = 5'd1; wb_data_i = 32'h20; tick();
    wb_en_i = 1'b0;

    // Backpressure: addi x10,x0,5 held for 3 cycles while addi x11,x0,7 waits
    present(32'h00500513, 32'h200);
    tick();
    id_ready_i = 1'b0;
    present(32'h00700593, 32'h204);
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold ready", 64'(if_ready_o), 64'd0);
      tick();
      chk("hold alu_b", 64'(id_alu_b_o), 64'd5);
      chk("hold rd",    64'(id_rd_o),    64'd10);
      chk("hold valid", 64'(id_valid_o), 64'd1);
    end
    id_ready_i = 1'b1;
    #1 chk("release ready", 64'(if_ready_o), 64'd1);
    tick();
    bundle("addi2", opbit(OP_ADDI), 32'd0, 32'd7, 5'd11);

    // lw x8,4(x1) flushed while held; add x9,x8,x0 then issues without stall
    present(32'h0040A403, 32'h300);
    tick();
    if_valid_i = 1'b0;
    bundle("lw", opbit(OP_LW), 32'h20, 32'd4, 5'd8);
    id_ready_i = 1'b0; flush_i = 1'b1;
    #1 chk("flush ready", 64'(if_ready_o), 64'd0);
    tick();
    flush_i = 1'b0; id_ready_i = 1'b1;
    chk("flush valid", 64'(id_valid_o), 64'd0);
    present(32'h000404B3, 32'h304);
    #1 chk("post-flush ready", 64'(if_ready_o), 64'd1);
    tick();
    bundle("add9", opbit(OP_ADD), 32'd0, 32'd0, 5'd9);

    // sw x2,8(x1) and bne x1,x2,-4: no destination, rs2 forwarded
    present(32'h0020A423, 32'h308);
    tick();
    bundle("sw", opbit(OP_SW), 32'h20, 32'd8, 5'd0);
    chk("sw rs2", 64'(id_rs2_o), 64'd15);
    present(32'hFE209EE3, 32'h30C);
    tick();
    bundle("bne", opbit(OP_BNE), 32'h20, 32'd15, 5'd0);
    chk("bne imm", 64'(id_imm_o), 64'hFFFF_FFFC);

    // Illegal word still issues
    present(32'hFFFF_FFFF, 32'h310);
    tick();
    chk("ill valid",   64'(id_valid_o),   64'd1);
    chk("ill flag",    64'(id_illegal_o), 64'd1);
    chk("ill op",      64'(id_op_o),      64'd0);
    chk("ill rd",      64'(id_rd_o),      64'd0);

    // add x13,x9,x9 stalls on busy x9 behind a held bundle; reset mid-stall
    id_ready_i = 1'b0;
    present(32'h009486B3, 32'h314);
    #1 chk("pre-rst stall", 64'(if_ready_o), 64'd0);
    rst = 1'b1;
    #1 chk("mid-rst valid",   64'(id_valid_o),   64'd0);
    chk("mid-rst op",      64'(id_op_o),      64'd0);
    chk("mid-rst rd",      64'(id_rd_o),      64'd0);
    chk("mid-rst illegal", 64'(id_illegal_o), 64'd0);
    chk("mid-rst pc",      64'(id_pc_o),      64'd0);
    rst = 1'b0;
    #1 chk("post-rst2 ready", 64'(if_ready_o), 64'd1);
    tick();
    if_valid_i = 1'b0;
    bundle("add13", opbit(OP_ADD), 32'd0, 32'd0, 5'd13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/riscv_decode_stage.md
# riscv_decode_stage

Decode/issue stage directly upstream of `riscv_alu`. Accepts fetched instructions over a valid/ready handshake, decodes RV32I into the one-hot `is_*` operation vector the ALU consumes, and reads the integer register file with write-back bypass. Holds a 32-entry scoreboard that stalls issue on read-after-write hazards. Presents a registered, handshaked operand bundle (`alu_a`, `alu_b`, op vector) to the execute stage.

## Interface
- `XLEN`, 32, datapath width; only 32 supported
- `NUM_OPS`, 40, width of the one-hot op vector; bit positions are fixed by package constants

- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `if_valid_i`  in  1  fetched instruction valid
- `if_ready_o`  out  1  stage can accept the instruction
- `if_instr_i`  in  32  instruction word
- `if_pc_i`  in  32  instruction PC
- `wb_en_i`  in  1  register write-back strobe
- `wb_rd_i`  in  5  write-back destination
- `wb_data_i`  in  32  write-back data
- `flush_i`  in  1  kill the instruction held in the ID output register
- `id_valid_o`  out  1  decoded bundle valid
- `id_ready_i`  in  1  execute stage accepts the bundle
- `id_op_o`  out  NUM_OPS  one-hot op; `is_jump` is additionally set with `is_jal`/`is_jalr`
- `id_alu_a_o`, `id_alu_b_o`  out  32  ALU operands
- `id_rs2_o`  out  32  rs2 value (store data, branch compare)
- `id_imm_o`  out  32  sign-extended immediate
- `id_rd_o`  out  5  destination register; 0 when the instruction writes no register
- `id_pc_o`  out  32  PC of the bundle
- `id_illegal_o`  out  1  undecodable instruction

## Operation
- Regfile: 32×32 storage; x0 reads 0. A write occurs when `wb_en_i` is high and `wb_rd_i != 0`. A read of the register being written in the same cycle returns `wb_data_i` (bypass).
- Immediates use the I/S/B/U/J formats, sign-extended. Shift-immediates use `imm[4:0]`.
- `alu_a` selection:
  - `if_pc_i` for auipc and jal
  - 0 for lui
  - rs1 otherwise
- `alu_b` selection:
  - rs2 for R-type and branches
  - imm otherwise
- Illegal instructions: unknown opcode/funct3/funct7, or SYSTEM with a word other than 0x00000073. The op vector is all-zero, `id_illegal_o=1`, `id_rd_o=0`, and the bundle still issues.
- `id_rd_o` is forced to 0 for branches, stores, ecall and illegal instructions.
- Scoreboard `busy[31:1]`:
  - Set `busy[rd]` on issue when `rd != 0`.
  - Clear `busy[wb_rd_i]` on write-back.
  - A same-cycle set and clear of the same register resolves to set.
- Hazard: an rs1 or rs2 that the instruction uses and that is busy, unless `wb_en_i` targets that register this cycle (served by bypass).
- `if_ready_o = !hazard && (!id_valid_o || id_ready_i)`
- Issue happens when `if_valid_i && if_ready_o`.
- Flush:
  - `flush_i` clears `id_valid_o` next cycle.
  - If the held bundle is not being accepted this cycle, flush also clears `busy[id_rd_o]`.
  - Flush takes priority over a same-cycle issue: `if_ready_o` is forced to 0 while `flush_i` is high.

## Timing
- Latency is 1 cycle from issue to `id_valid_o`.
- The output register holds its value while `id_valid_o && !id_ready_i`. Full throughput is 1 instruction per cycle with no hazards.
- `if_ready_o` is combinational from `id_ready_i`, `wb_*`, `flush_i` and the scoreboard.
- Reset values:
  - `id_valid_o=0`
  - all `id_*` data outputs = 0
  - `busy` = 0
  - regfile = 0
- Reset mid-stall drops the held bundle and all pending hazards.
- After reset deasserts, `if_ready_o=1` in the first cycle.

## Structure
- Package `riscv_pkg` holds:
  - opcode/funct3/funct7 localparams
  - `OP_*` bit indices of the one-hot vector, in `is_*` order: branches, ALU, lui/auipc/jal/jalr/jump, loads, stores, ecall
  - `NUM_OPS`
- Natural sub-module: `riscv_regfile`, with 2 read ports, 1 write port, bypass and x0 handling.
- The top-level wrapper fans `id_op_o` bits out to the ALU `is_*` ports.

## Test plan
- Write x1=10 and x2=15 via `wb_*`, then issue `add x3,x1,x2` (0x002081B3) -> `is_add` is the only set bit apart from none, `alu_a=10`, `alu_b=15`, `id_rd_o=3`, valid after 1 cycle.
- Issue `addi x5,x0,-1` then `and x6,x5,x5` back-to-back -> the second stalls (`if_ready_o=0`) until `wb_en_i` with rd=5, data 0xFFFFFFFF. It issues in that same cycle with `alu_a=alu_b=0xFFFFFFFF`.
- Issue `auipc x7,0x1` at PC 0x100 -> `alu_a=0x100`, `alu_b=0x1000`, `is_auipc`. Issue `jal x1,8` -> `is_jal` and `is_jump` both set.
- Hold `id_ready_i=0` for 3 cycles with `if_valid_i=1` -> the bundle is stable and `if_ready_o=0`. Release -> the next instruction issues the following cycle.
- Issue `lw x8,4(x1)`, then flush while it is held -> `id_valid_o=0` next cycle, and a following `add x9,x8,x0` issues without stall.
- Issue 0xFFFFFFFF -> `id_illegal_o=1`, op=0, `rd=0`. Assert `rst` mid-stall -> all outputs 0 and `busy` cleared.
